harris_corner: RTL and testbench

- Streaming Harris corner-response accelerator for one grayscale frame held in a padded global buffer.
- Pulls one 16-bit pixel per cycle from the upstream padded16 buffer and computes Sobel gradients.
- Forms the gradient products, box-sums them over 3x3 windows and emits one 16-bit corner response per interior pixel to the downstream hw_output buffer.

---
 rtl/harris_pkg.sv | 10 +
 rtl/harris_win3x3.sv | 66 ++++++
 rtl/harris_corner.sv | 181 ++++++++++++++++++
 tb/tb_harris_corner.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/harris_pkg.sv
// Shared types and constants for the Harris corner-response pipeline.
package harris_pkg;
    typedef logic        [15:0] pix_t;
    typedef logic signed [15:0] sval_t;
    typedef logic signed [19:0] grad_t;

    localparam int GRAD_SHIFT = 7;
    localparam int K_SHIFT    = 4;
    localparam int PIPE_LAT   = 4;
endpackage

// File: rtl/harris_win3x3.sv
// Two W-deep line buffers feeding a 3x3 sliding window; win_vld_o marks windows
// that lie fully inside the frame (never straddling a row end).
module harris_win3x3 #(
    parameter int DW = 16,
    parameter int W  = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_i,
    input  logic                    in_vld_i,
    input  logic [DW-1:0]           in_data_i,
    output logic                    win_vld_o,
    output logic [2:0][2:0][DW-1:0] win_o
);
    localparam int XW = (W > 1) ? $clog2(W) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(W - 1);

    logic [XW-1:0]           x_q;
    logic [1:0]              y_q;
    logic                    vld_q;
    logic [2:0][2:0][DW-1:0] win_q;
    logic [DW-1:0]           lb0_q [W];
    logic [DW-1:0]           lb1_q [W];

    // Line buffers hold data only; stale rows are never used before two rows are written
    always_ff @(posedge clk) begin
        if (in_vld_i && !clr_i) begin
            lb0_q[x_q] <= in_data_i;
            lb1_q[x_q] <= lb0_q[x_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q   <= '0;
            y_q   <= '0;
            vld_q <= 1'b0;
            win_q <= '0;
        end else if (clr_i) begin
            x_q   <= '0;
            y_q   <= '0;
            vld_q <= 1'b0;
            win_q <= '0;
        end else begin
            vld_q <= in_vld_i && (x_q >= XW'(2)) && (y_q == 2'd2);
            if (in_vld_i) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][2];
                end
                win_q[0][2] <= lb1_q[x_q];
                win_q[1][2] <= lb0_q[x_q];
                win_q[2][2] <= in_data_i;
                if (x_q == X_LAST) begin
                    x_q <= '0;
                    if (y_q != 2'd2) y_q <= y_q + 2'd1;
                end else begin
                    x_q <= x_q + XW'(1);
                end
            end
        end
    end

    assign win_vld_o = vld_q;
    assign win_o     = win_q;
endmodule

// File: rtl/harris_corner.sv
// Streaming Harris corner response over a padded IMG_W x IMG_H frame.
// Define HARRIS_THRESH_EN to zero every response not above THRESH.
module harris_corner
    import harris_pkg::*;
#(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int THRESH = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    output logic        padded16_stencil_op_hcompute_padded16_global_wrapper_stencil_read_en,
    input  logic [15:0] padded16_stencil_op_hcompute_padded16_global_wrapper_stencil_read,
    output logic        hw_output_stencil_op_hcompute_hw_output_stencil_write_valid,
    output logic [15:0] hw_output_stencil_op_hcompute_hw_output_stencil_write
);
    localparam int NPIX = IMG_W * IMG_H;
    localparam int CW   = $clog2(NPIX);
    localparam logic [CW-1:0] CNT_LAST = CW'(NPIX - 1);

    function automatic grad_t col_sum(input pix_t a, input pix_t b, input pix_t c);
        grad_t ea, eb, ec;
        ea = {4'b0, a};
        eb = {4'b0, b};
        ec = {4'b0, c};
        return ea + (eb <<< 1) + ec;
    endfunction

    function automatic sval_t grad_shr(input grad_t g);
        grad_t s;
        s = g >>> GRAD_SHIFT;
        return s[15:0];
    endfunction

    function automatic sval_t mul_shr(input sval_t a, input sval_t b);
        logic signed [31:0] p;
        p = 32'(a) * 32'(b);
        return p[GRAD_SHIFT+15:GRAD_SHIFT];
    endfunction

    logic          rd_en_q, done_q;
    logic [CW-1:0] cnt_q;

    // One contiguous raster burst per frame; done_q holds the stream off until flush
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else if (flush) begin
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else if (!done_q) begin
            if (!rd_en_q) begin
                rd_en_q <= 1'b1;
            end else if (cnt_q == CNT_LAST) begin
                rd_en_q <= 1'b0;
                done_q  <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    // Stage p0: pixel window
    logic                    pwin_vld;
    logic [2:0][2:0][15:0]   pwin;
    logic                    pix_center_unused;

    harris_win3x3 #(.DW(16), .W(IMG_W)) u_pix_win (
        .clk       (clk),
        .rst       (rst_n),
        .clr_i     (flush),
        .in_vld_i  (rd_en_q),
        .in_data_i (padded16_stencil_op_hcompute_padded16_global_wrapper_stencil_read),
        .win_vld_o (pwin_vld),
        .win_o     (pwin)
    );
    assign pix_center_unused = ^pwin[1][1];

    // Stage p1: Sobel gradients
    grad_t gx_d, gy_d;
    sval_t gx_p1, gy_p1;
    logic  vld_p1;

    assign gx_d = col_sum(pwin[0][2], pwin[1][2], pwin[2][2]) - col_sum(pwin[0][0], pwin[1][0], pwin[2][0]);
    assign gy_d = col_sum(pwin[2][0], pwin[2][1], pwin[2][2]) - col_sum(pwin[0][0], pwin[0][1], pwin[0][2]);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)      vld_p1 <= 1'b0;
        else if (flush) vld_p1 <= 1'b0;
        else            vld_p1 <= pwin_vld;
    end

    always_ff @(posedge clk) begin
        gx_p1 <= grad_shr(gx_d);
        gy_p1 <= grad_shr(gy_d);
    end

    // Stage p2: gradient products windowed over the interior gradient field
    logic [47:0]           prod_d;
    logic                  vld_p2;
    logic [2:0][2:0][47:0] win_p2;

    assign prod_d = {mul_shr(gx_p1, gx_p1), mul_shr(gy_p1, gy_p1), mul_shr(gx_p1, gy_p1)};

    harris_win3x3 #(.DW(48), .W(IMG_W - 2)) u_prod_win (
        .clk       (clk),
        .rst       (rst_n),
        .clr_i     (flush),
        .in_vld_i  (vld_p1),
        .in_data_i (prod_d),
        .win_vld_o (vld_p2),
        .win_o     (win_p2)
    );

    // Stage p3: box sums
    sval_t lxx_d, lyy_d, lxy_d;
    sval_t lxx_p3, lyy_p3, lxy_p3;
    logic  vld_p3;

    always_comb begin
        lxx_d = '0;
        lyy_d = '0;
        lxy_d = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                lxx_d = lxx_d + sval_t'(win_p2[r][c][47:32]);
                lyy_d = lyy_d + sval_t'(win_p2[r][c][31:16]);
                lxy_d = lxy_d + sval_t'(win_p2[r][c][15:0]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)      vld_p3 <= 1'b0;
        else if (flush) vld_p3 <= 1'b0;
        else            vld_p3 <= vld_p2;
    end

    always_ff @(posedge clk) begin
        lxx_p3 <= lxx_d;
        lyy_p3 <= lyy_d;
        lxy_p3 <= lxy_d;
    end

    // Stage p4: response and output register
    sval_t ksum_d, r_d, res_d;
    logic  wvld_q;
    sval_t wr_q;

    assign ksum_d = lxx_p3 + lyy_p3;
    assign r_d    = mul_shr(lxx_p3, lyy_p3) - mul_shr(lxy_p3, lxy_p3)
                  - (mul_shr(ksum_d, ksum_d) >>> K_SHIFT);

`ifdef HARRIS_THRESH_EN
    localparam sval_t THR = sval_t'(THRESH);
    assign res_d = (r_d > THR) ? r_d : '0;
`else
    assign res_d = r_d;
`endif

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wvld_q <= 1'b0;
            wr_q   <= '0;
        end else if (flush) begin
            wvld_q <= 1'b0;
            wr_q   <= '0;
        end else begin
            wvld_q <= vld_p3;
            if (vld_p3) wr_q <= res_d;
        end
    end

    assign padded16_stencil_op_hcompute_padded16_global_wrapper_stencil_read_en = rd_en_q;
    assign hw_output_stencil_op_hcompute_hw_output_stencil_write_valid          = wvld_q;
    assign hw_output_stencil_op_hcompute_hw_output_stencil_write                = wr_q;
endmodule

// File: tb/tb_harris_corner.sv
// Directed bench for harris_corner: framing, latency, reset/flush and response values
// against a direct 2-D reference of the corner-response arithmetic.
module tb_harris_corner;
    import harris_pkg::*;

    localparam int W    = 64;
    localparam int H    = 64;
    localparam int N    = W * H;
    localparam int OW   = W - 4;
    localparam int OH   = H - 4;
    localparam int NOUT = OW * OH;

`ifdef HARRIS_THRESH_EN
    localparam logic [15:0] RAMP_R = 16'h0000;
`else
    localparam logic [15:0] RAMP_R = 16'hFFFE;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [15:0] pix;
    logic        rd_en;
    logic        wvld;
    logic [15:0] wr;

    always #5 clk = ~clk;

    harris_corner #(.IMG_W(W), .IMG_H(H), .THRESH(1)) dut (
        .clk   (clk),
        .rst_n (rst),
        .flush (flush),
        .padded16_stencil_op_hcompute_padded16_global_wrapper_stencil_read_en (rd_en),
        .padded16_stencil_op_hcompute_padded16_global_wrapper_stencil_read    (pix),
        .hw_output_stencil_op_hcompute_hw_output_stencil_write_valid          (wvld),
        .hw_output_stencil_op_hcompute_hw_output_stencil_write                (wr)
    );

    int          img  [N];
    logic [15:0] expv [NOUT];
    logic [15:0] got  [NOUT];
    logic [15:0] prev [NOUT];

    int checks = 0;
    int errors = 0;
    int rd_idx, rd_cnt, out_cnt, first_smp, rd_first, rd_last, cyc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] ex);
        checks++;
        assert (obs === ex)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, ex);
        end
    endtask

    function automatic int s16(input longint v);
        logic signed [15:0] t;
        t = v[15:0];
        return int'(t);
    endfunction

    function automatic int pr(input int a, input int b);
        longint p;
        p = longint'(a) * longint'(b);
        return s16(p >>> 7);
    endfunction

    function automatic int px(input int x, input int y);
        return img[y * W + x];
    endfunction

    function automatic int model_r(input int x, input int y);
        int gx, gy, sxx, syy, sxy, cx, cy, s, r;
        sxx = 0;
        syy = 0;
        sxy = 0;
        for (int dy = 0; dy < 3; dy++) begin
            for (int dx = 0; dx < 3; dx++) begin
                cx = x + 1 + dx;
                cy = y + 1 + dy;
                gx = s16((px(cx+1, cy-1) + 2*px(cx+1, cy) + px(cx+1, cy+1)
                        - px(cx-1, cy-1) - 2*px(cx-1, cy) - px(cx-1, cy+1)) >>> 7);
                gy = s16((px(cx-1, cy+1) + 2*px(cx, cy+1) + px(cx+1, cy+1)
                        - px(cx-1, cy-1) - 2*px(cx, cy-1) - px(cx+1, cy-1)) >>> 7);
                sxx += pr(gx, gx);
                syy += pr(gy, gy);
                sxy += pr(gx, gy);
            end
        end
        sxx = s16(sxx);
        syy = s16(syy);
        sxy = s16(sxy);
        s   = s16(sxx + syy);
        r   = s16(pr(sxx, syy) - pr(sxy, sxy) - (pr(s, s) >>> 4));
`ifdef HARRIS_THRESH_EN
        if (!(r > 1)) r = 0;
`endif
        return r;
    endfunction

    task automatic build_exp();
        for (int y = 0; y < OH; y++)
            for (int x = 0; x < OW; x++)
                expv[y*OW + x] = 16'(model_r(x, y));
    endtask

    task automatic clear_stats();
        rd_idx = 0; rd_cnt = 0; out_cnt = 0;
        first_smp = -1; rd_first = -1; rd_last = -1; cyc = 0;
    endtask

    // One negedge: observe outputs, then drive the pixel for the next sampling edge
    task automatic step();
        @(negedge clk);
        cyc++;
        if (wvld) begin
            if (first_smp < 0) first_smp = rd_idx - 1;
            if (out_cnt < NOUT) begin
                got[out_cnt] = wr;
                check($sformatf("resp[%0d]", out_cnt), wr, expv[out_cnt]);
            end
            out_cnt++;
        end
        if (rd_en) begin
            if (rd_first < 0) rd_first = cyc;
            rd_last = cyc;
            rd_cnt++;
            pix = (rd_idx < N) ? 16'(img[rd_idx]) : 16'h0000;
            rd_idx++;
        end
    endtask

    task automatic run_frame(input string tag);
        clear_stats();
        for (int c = 0; c < N + 64; c++) step();
        check({tag, ".rd_first"},  rd_first, 1);
        check({tag, ".rd_cnt"},    rd_cnt, N);
        check({tag, ".rd_span"},   rd_last - rd_first + 1, N);
        check({tag, ".n_out"},     out_cnt, NOUT);
        check({tag, ".first_vld"}, first_smp, 4*W + 4 + PIPE_LAT);
        check({tag, ".rd_en_end"}, rd_en, 1'b0);
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        check("flush.rd_en", rd_en, 1'b0);
        flush = 1'b0;
    endtask

    initial begin
        int reached;
        int diff;
        rst   = 1'b1;
        flush = 1'b0;
        pix   = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst.rd_en", rd_en, 1'b0);
        check("rst.wvld",  wvld,  1'b0);
        check("rst.write", wr,    16'h0000);

        // Flat image: all responses zero
        for (int i = 0; i < N; i++) img[i] = 100;
        build_exp();
        @(negedge clk);
        rst = 1'b0;
        run_frame("const");
        check("const.r_first", got[0], 16'h0000);
        check("const.r_last",  got[NOUT-1], 16'h0000);

        // Horizontal ramp of 512 per column: gx=32, Ixx=8, lxx=72, r=-2
        for (int i = 0; i < N; i++) img[i] = (i % W) * 512;
        build_exp();
        do_flush();
        run_frame("ramp");
        check("ramp.r_first", got[0], RAMP_R);
        check("ramp.r_mid",   got[NOUT/2 + 7], RAMP_R);
        check("ramp.r_last",  got[NOUT-1], RAMP_R);

        // Random frame
        for (int i = 0; i < N; i++) img[i] = int'($urandom_range(0, 65535));
        build_exp();
        do_flush();
        run_frame("rand");

        // Second random frame, interrupted by an asynchronous reset mid-stream
        for (int i = 0; i < N; i++) img[i] = int'($urandom_range(0, 65535));
        build_exp();
        do_flush();
        clear_stats();
        reached = 0;
        for (int c = 0; c < N; c++) begin
            step();
            if (rd_idx > 2000 && wvld) begin
                reached = 1;
                break;
            end
        end
        check("mid.reached", reached, 1);
        #2 rst = 1'b1;
        #1;
        check("mid.rd_en_async", rd_en, 1'b0);
        check("mid.wvld_async",  wvld,  1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_frame("restart");
        for (int i = 0; i < NOUT; i++) prev[i] = got[i];

        // Flush after frame end, same data again
        do_flush();
        run_frame("reflush");
        diff = 0;
        for (int i = 0; i < NOUT; i++) if (got[i] !== prev[i]) diff++;
        check("reflush.same_as_prev", diff, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
